// File: rtl/step_ctrl_pkg.sv
// Shared types for the core run/step controller: FSM state encoding and status widths.
// Pure declarations, no logic; no latency, no backpressure.
package step_ctrl_pkg;

   localparam int PULSE_CNT_W = 16;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   // Terminal prescaler value for a divide ratio, sized to the prescaler width.
   function automatic int unsigned div_top(input int unsigned div);
      return div - 1;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; rise is combinational from d and the 1-cycle history.
// History resets to 1 so a level held through reset never reports an edge; no backpressure.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b1;
      end else begin
         prev <= d;
      end
   end

   assign rise = d & ~prev;

endmodule

// File: rtl/core_step_ctrl.sv
// Run/halt/single-step clock-enable generator for the core, with pulse count and heartbeat status.
// core_en registered: one cycle after a sampled step edge, DIV cycles after RUN entry; no backpressure.
module core_step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int SLOW_DIV = 4194304,
   parameter int FAST_DIV = 262144,
   parameter int DIV_W    = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_run,
   input  logic                   btn_step,
   input  logic                   btn_fast,
   input  logic                   halt_req,
   output logic                   core_en,
   output logic                   running,
   output logic [PULSE_CNT_W-1:0] pulse_cnt,
   output logic                   heartbeat
);

   localparam logic [DIV_W-1:0] SLOW_TOP = DIV_W'(div_top(SLOW_DIV));
   localparam logic [DIV_W-1:0] FAST_TOP = DIV_W'(div_top(FAST_DIV));

   state_t             state;
   state_t             state_nxt;
   logic [DIV_W-1:0]   presc;
   logic [DIV_W-1:0]   presc_nxt;
   logic [DIV_W-1:0]   top_sel;
   logic               en_nxt;
   logic               run_rise;
   logic               step_rise;
   logic               tick;

   rise_detect u_run_rise (
      .clk   (clk),
      .reset (reset),
      .d     (btn_run),
      .rise  (run_rise)
   );

   rise_detect u_step_rise (
      .clk   (clk),
      .reset (reset),
      .d     (btn_step),
      .rise  (step_rise)
   );

   // >= rather than == so a slow->fast switch past the fast terminal fires at once.
   assign top_sel = btn_fast ? FAST_TOP : SLOW_TOP;
   assign tick    = (presc >= top_sel);

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      en_nxt    = 1'b0;
      case (state)
         HALT: begin
            if (run_rise && !halt_req) begin
               state_nxt = RUN;
               presc_nxt = '0;
            end else if (step_rise) begin
               state_nxt = STEP;
               en_nxt    = 1'b1;
            end
         end
         STEP: begin
            state_nxt = HALT;
         end
         RUN: begin
            // Exit takes priority: a tick coinciding with the exit decision is dropped.
            if (run_rise || halt_req) begin
               state_nxt = HALT;
            end else if (tick) begin
               presc_nxt = '0;
               en_nxt    = 1'b1;
            end else begin
               presc_nxt = presc + DIV_W'(1);
            end
         end
         default: begin
            state_nxt = HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HALT;
         presc     <= '0;
         core_en   <= 1'b0;
         running   <= 1'b0;
         pulse_cnt <= '0;
         heartbeat <= 1'b0;
      end else begin
         state   <= state_nxt;
         presc   <= presc_nxt;
         core_en <= en_nxt;
         running <= (state_nxt == RUN);
         if (core_en) begin
            pulse_cnt <= pulse_cnt + PULSE_CNT_W'(1);
            heartbeat <= ~heartbeat;
         end
      end
   end

endmodule
